// File: rtl/pdm_rx.sv
// rtl/pdm_rx.sv - PDM microphone-pair receiver with ones-count decimation
//
// Purpose: samples a 1-bit PDM stream on micclk edges, counts ones per
// channel over 2^DEC_LOG2 bit pairs and hands the count pair downstream
// through a valid/ready handshake.
//
// Macro PDM_RX_STEREO_EN: when defined, the right channel is sampled on
// falling micclk edges. When undefined, the design is mono: pcm_r is tied
// to 0 and each enabled rising edge completes a pair.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset
//   en         receiver enable; low discards the partial window
//   micclk     microphone clock, already registered in the clk domain
//   pdm_in     PDM data pin (asynchronous, synchronized internally)
//   pcm_l      left ones-count of the last completed window
//   pcm_r      right ones-count (0 in mono builds)
//   pcm_valid  a sample pair is held for the consumer
//   pcm_ready  consumer accepts when pcm_valid & pcm_ready
//   ovr        sticky overrun flag
//   ovr_clr    clears ovr (a simultaneous overrun wins)
module pdm_rx #(
  parameter int DEC_LOG2 = 6,
  parameter int W        = DEC_LOG2 + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         micclk,
  input  logic         pdm_in,
  output logic [W-1:0] pcm_l,
  output logic [W-1:0] pcm_r,
  output logic         pcm_valid,
  input  logic         pcm_ready,
  output logic         ovr,
  input  logic         ovr_clr
);

  localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;

  logic                sync1_q, sync2_q;
  logic                micclk_d_q;
  logic [W-1:0]        acc_l_q, acc_l_d;
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic [W-1:0]        pcm_l_q, pcm_l_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                rise;
  logic                pair_done;
  logic                win_done;
  logic [W-1:0]        pdm_w;

  assign rise  = micclk & ~micclk_d_q;
  assign pdm_w = {{(W-1){1'b0}}, sync2_q};

`ifdef PDM_RX_STEREO_EN
  logic         fall;
  logic         got_l_q, got_l_d;
  logic [W-1:0] acc_r_q, acc_r_d;
  logic [W-1:0] pcm_r_q, pcm_r_d;

  assign fall = ~micclk & micclk_d_q;

  // Pairing: a rise captures left, the following fall captures right and
  // closes the pair. A fall with no preceding rise is ignored so the
  // channels cannot swap after reset or re-enable.
  always_comb begin
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    got_l_d   = got_l_q;
    pair_done = 1'b0;
    if (!en) begin
      acc_l_d = '0;
      acc_r_d = '0;
      got_l_d = 1'b0;
    end else if (rise) begin
      acc_l_d = acc_l_q + pdm_w;
      got_l_d = 1'b1;
    end else if (fall && got_l_q) begin
      acc_r_d   = acc_r_q + pdm_w;
      got_l_d   = 1'b0;
      pair_done = 1'b1;
    end
  end
`else
  always_comb begin
    acc_l_d   = acc_l_q;
    pair_done = 1'b0;
    if (!en) begin
      acc_l_d = '0;
    end else if (rise) begin
      acc_l_d   = acc_l_q + pdm_w;
      pair_done = 1'b1;
    end
  end
`endif

  assign win_done = pair_done && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (pair_done) begin
      // Natural wrap to 0 at the end of the window.
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output register and handshake. A completing window always loads; an
  // unconsumed previous pair at that moment is an overrun.
  always_comb begin
    pcm_l_d = pcm_l_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && pcm_ready) begin
      valid_d = 1'b0;
    end
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (win_done) begin
      pcm_l_d = acc_l_d;
      valid_d = 1'b1;
      if (valid_q && !pcm_ready) begin
        ovr_d = 1'b1;
      end
    end
  end

`ifdef PDM_RX_STEREO_EN
  always_comb begin
    pcm_r_d = pcm_r_q;
    if (win_done) begin
      pcm_r_d = acc_r_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      micclk_d_q <= 1'b0;
      acc_l_q    <= '0;
      cnt_q      <= '0;
      pcm_l_q    <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= pdm_in;
      sync2_q    <= sync1_q;
      micclk_d_q <= micclk;
      // The accumulator restarts at 0 once its count has been loaded out.
      acc_l_q    <= win_done ? '0 : acc_l_d;
      cnt_q      <= cnt_d;
      pcm_l_q    <= pcm_l_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef PDM_RX_STEREO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r_q <= '0;
      got_l_q <= 1'b0;
      pcm_r_q <= '0;
    end else begin
      acc_r_q <= win_done ? '0 : acc_r_d;
      got_l_q <= got_l_d;
      pcm_r_q <= pcm_r_d;
    end
  end

  assign pcm_r = pcm_r_q;
`else
  assign pcm_r = '0;
`endif

  assign pcm_l     = pcm_l_q;
  assign pcm_valid = valid_q;
  assign ovr       = ovr_q;

endmodule
